// File: rtl/bus_ctrl_pkg.sv
// rtl/bus_ctrl_pkg.sv - shared types and constants for the DSP bus cycle controller
package bus_ctrl_pkg;

  localparam int DATA_W = 16;
  localparam int AB_W   = 8;

  localparam logic [DATA_W-1:0] DEFAULT_DATA_C = 16'h3333;
  localparam logic [AB_W-1:0]   STAT_ADDR_C    = 8'hFF;

  localparam int STAT_CONFLICT_BIT = 15;
  localparam int STAT_PROTO_BIT    = 14;
  localparam int STAT_CNT_W        = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_SETTLE,
    ST_WR_ACTIVE,
    ST_RD_SETUP,
    ST_RD_DRIVE,
    ST_TURNAROUND
  } bus_state_e;

  function automatic logic [DATA_W-1:0] status_word(
    input logic                  conflict,
    input logic                  proto,
    input logic [STAT_CNT_W-1:0] cnt
  );
    logic [DATA_W-1:0] w;
    w                    = '0;
    w[STAT_CONFLICT_BIT] = conflict;
    w[STAT_PROTO_BIT]    = proto;
    w[STAT_CNT_W-1:0]    = cnt;
    return w;
  endfunction

endpackage

// File: rtl/bus_src_prio_enc.sv
// rtl/bus_src_prio_enc.sv - fixed-priority encoder (index 0 wins) with more-than-one-hot detect
module bus_src_prio_enc #(
  parameter int NSRC  = 8,
  parameter int IDX_W = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic [NSRC-1:0]  i_avail,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any,
  output logic             o_multi
);

  always_comb begin
    o_idx   = '0;
    o_any   = 1'b0;
    o_multi = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (i_avail[i]) begin
        if (o_any) begin
          o_multi = 1'b1;
        end else begin
          o_idx = IDX_W'(i);
          o_any = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bus_cycle_ctrl.sv
// rtl/bus_cycle_ctrl.sv - DSP external-bus cycle sequencer: write settle, read arbitration, status
module bus_cycle_ctrl
  import bus_ctrl_pkg::*;
#(
  parameter int                NSRC         = 8,
  parameter int                WR_SETTLE    = 2,
  parameter int                TURN         = 1,
  parameter logic [DATA_W-1:0] DEFAULT_DATA = DEFAULT_DATA_C,
  parameter logic [AB_W-1:0]   STAT_ADDR    = STAT_ADDR_C,
  parameter int                AB_OFFSET    = 0
) (
  input  logic                     xclk,
  input  logic                     reset,
  input  logic                     cs,
  input  logic                     re,
  input  logic                     we,
  input  logic [AB_W-1:0]          ab,
  input  logic [DATA_W-1:0]        db_in,
  input  logic [NSRC-1:0]          src_avail,
  input  logic [DATA_W*NSRC-1:0]   src_data,
  output logic                     write_qualified,
  output logic                     read_qualified,
  output logic [DATA_W-1:0]        db_out,
  output logic                     db_oe,
  output logic                     conflict_flag,
  output logic                     proto_err_flag,
  output logic [STAT_CNT_W-1:0]    conflict_count
);

  localparam int              IDX_W       = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam logic [AB_W-1:0] STAT_MATCH  = AB_W'(int'(STAT_ADDR) + AB_OFFSET);
  localparam logic [7:0]      SETTLE_LAST = 8'(WR_SETTLE - 1);
  localparam logic [7:0]      TURN_LAST   = 8'(TURN - 1);

  bus_state_e              r_state;
  bus_state_e              w_next;
  logic [7:0]              r_cnt;
  logic                    r_wr_first;
  logic                    r_conf_seen;
  logic                    r_conflict;
  logic                    r_proto;
  logic [STAT_CNT_W-1:0]   r_count;
  logic [DATA_W-1:0]       r_db_out;

  logic                    w_cnt_clr;
  logic                    w_load;
  logic                    w_proto;
  logic                    w_stat_hit;
  logic                    w_conflict;
  logic                    w_clear;
  logic [IDX_W-1:0]        w_idx;
  logic                    w_any;
  logic                    w_multi;
  logic [DATA_W-1:0]       w_sel_word;
  logic                    w_unused_db;

  bus_src_prio_enc #(
    .NSRC  (NSRC),
    .IDX_W (IDX_W)
  ) u_prio (
    .i_avail (src_avail),
    .o_idx   (w_idx),
    .o_any   (w_any),
    .o_multi (w_multi)
  );

  always_ff @(posedge xclk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_cnt_clr = 1'b0;
    w_load    = 1'b0;
    w_proto   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!cs) begin
          if (!re && !we) begin
            w_proto = 1'b1;
          end else if (!we) begin
            w_next    = (WR_SETTLE == 0) ? ST_WR_ACTIVE : ST_WR_SETTLE;
            w_cnt_clr = 1'b1;
          end else if (!re) begin
            w_next = ST_RD_SETUP;
          end
        end
      end
      ST_WR_SETTLE: begin
        if (we || cs)                 w_next = ST_IDLE;
        else if (r_cnt == SETTLE_LAST) w_next = ST_WR_ACTIVE;
      end
      ST_WR_ACTIVE: begin
        if (we || cs) w_next = ST_IDLE;
      end
      ST_RD_SETUP: begin
        if (re || cs) begin
          w_next = ST_IDLE;
        end else begin
          w_next = ST_RD_DRIVE;
          w_load = 1'b1;
        end
      end
      ST_RD_DRIVE: begin
        if (re || cs) begin
          w_next    = (TURN == 0) ? ST_IDLE : ST_TURNAROUND;
          w_cnt_clr = 1'b1;
        end else begin
          w_load = 1'b1;
        end
      end
      ST_TURNAROUND: begin
        if (r_cnt == TURN_LAST) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_stat_hit  = (ab == STAT_MATCH);
  assign w_conflict  = w_load && w_multi && !w_stat_hit;
  assign w_clear     = (r_state == ST_WR_ACTIVE) && r_wr_first && w_stat_hit && db_in[0];
  assign w_sel_word  = src_data[int'(w_idx)*DATA_W +: DATA_W];
  assign w_unused_db = ^db_in[DATA_W-1:1];

  // One counter serves both the write settle delay and the read turnaround gap.
  always_ff @(posedge xclk) begin
    if (reset)                                                   r_cnt <= '0;
    else if (w_cnt_clr)                                          r_cnt <= '0;
    else if (r_state == ST_WR_SETTLE || r_state == ST_TURNAROUND) r_cnt <= r_cnt + 8'd1;
  end

  always_ff @(posedge xclk) begin
    if (reset) begin
      r_wr_first  <= 1'b0;
      r_conf_seen <= 1'b0;
    end else begin
      r_wr_first <= (w_next == ST_WR_ACTIVE) && (r_state != ST_WR_ACTIVE);
      if (w_next == ST_RD_SETUP) r_conf_seen <= 1'b0;
      else if (w_conflict)       r_conf_seen <= 1'b1;
    end
  end

  // A status clear outranks any flag set or count on the same edge.
  always_ff @(posedge xclk) begin
    if (reset || w_clear) begin
      r_conflict <= 1'b0;
      r_proto    <= 1'b0;
      r_count    <= '0;
    end else begin
      if (w_proto) r_proto <= 1'b1;
      if (w_conflict) begin
        r_conflict <= 1'b1;
        if (!r_conf_seen && r_count != {STAT_CNT_W{1'b1}}) r_count <= r_count + 1'b1;
      end
    end
  end

  always_ff @(posedge xclk) begin
    if (reset) begin
      r_db_out <= '0;
    end else if (w_load) begin
      if (w_stat_hit)  r_db_out <= status_word(r_conflict, r_proto, r_count);
      else if (w_any)  r_db_out <= w_sel_word;
      else             r_db_out <= DEFAULT_DATA;
    end
  end

  assign write_qualified = (r_state == ST_WR_ACTIVE);
  assign read_qualified  = (r_state == ST_RD_SETUP) || (r_state == ST_RD_DRIVE);
  assign db_oe           = (r_state == ST_RD_DRIVE);
  assign db_out          = r_db_out;
  assign conflict_flag   = r_conflict;
  assign proto_err_flag  = r_proto;
  assign conflict_count  = r_count;

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// tb/tb_bus_cycle_ctrl.sv - self-checking bench for bus_cycle_ctrl
module tb_bus_cycle_ctrl;

  localparam int NSRC      = 8;
  localparam int WR_SETTLE = 2;
  localparam int TURN      = 1;
  localparam int MI = 0, MW = 1, MR = 2, MT = 3;

  logic                 xclk = 1'b0;
  logic                 reset;
  logic                 cs, re, we;
  logic [7:0]           ab;
  logic [15:0]          db_in;
  logic [NSRC-1:0]      src_avail;
  logic [16*NSRC-1:0]   src_data;
  logic                 write_qualified, read_qualified, db_oe;
  logic [15:0]          db_out;
  logic                 conflict_flag, proto_err_flag;
  logic [7:0]           conflict_count;

  int errors = 0;
  int checks = 0;

  int         m_mode  = MI;
  int         m_age   = 0;
  int         m_tleft = 0;
  logic       m_conf  = 1'b0;
  logic       m_proto = 1'b0;
  logic       m_seen  = 1'b0;
  logic [7:0] m_cnt   = 8'h00;
  logic [15:0] m_db   = 16'h0000;

  bus_cycle_ctrl #(
    .NSRC      (NSRC),
    .WR_SETTLE (WR_SETTLE),
    .TURN      (TURN)
  ) dut (
    .xclk            (xclk),
    .reset           (reset),
    .cs              (cs),
    .re              (re),
    .we              (we),
    .ab              (ab),
    .db_in           (db_in),
    .src_avail       (src_avail),
    .src_data        (src_data),
    .write_qualified (write_qualified),
    .read_qualified  (read_qualified),
    .db_out          (db_out),
    .db_oe           (db_oe),
    .conflict_flag   (conflict_flag),
    .proto_err_flag  (proto_err_flag),
    .conflict_count  (conflict_count)
  );

  always #5 xclk = ~xclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: mode plus edges elapsed since the request was sampled.
  task automatic model_step();
    logic [15:0] word;
    if (reset) begin
      m_mode = MI; m_age = 0; m_tleft = 0;
      m_conf = 1'b0; m_proto = 1'b0; m_seen = 1'b0; m_cnt = 8'h00; m_db = 16'h0000;
      return;
    end
    case (m_mode)
      MI: begin
        if (!cs) begin
          if (!re && !we) m_proto = 1'b1;
          else if (!we) begin m_mode = MW; m_age = 0; end
          else if (!re) begin m_mode = MR; m_age = 0; m_seen = 1'b0; end
        end
      end
      MW: begin
        if (m_age == WR_SETTLE && ab == 8'hFF && db_in[0]) begin
          m_conf = 1'b0; m_proto = 1'b0; m_cnt = 8'h00;
        end
        if (we || cs) m_mode = MI;
        else m_age++;
      end
      MR: begin
        if (re || cs) begin
          m_mode  = (m_age == 0 || TURN == 0) ? MI : MT;
          m_tleft = TURN;
        end else begin
          if (ab == 8'hFF) begin
            word = {m_conf, m_proto, 6'b0, m_cnt};
          end else begin
            word = 16'h3333;
            for (int i = NSRC - 1; i >= 0; i--)
              if (src_avail[i]) word = src_data[16*i +: 16];
            if ($countones(src_avail) > 1) begin
              m_conf = 1'b1;
              if (!m_seen && m_cnt < 8'hFF) m_cnt = m_cnt + 8'd1;
              m_seen = 1'b1;
            end
          end
          m_db = word;
          m_age++;
        end
      end
      default: begin
        m_tleft--;
        if (m_tleft == 0) m_mode = MI;
      end
    endcase
  endtask

  initial forever begin
    @(posedge xclk);
    model_step();
  end

  initial begin
    @(posedge xclk);
    forever begin
      @(negedge xclk);
      chk("m_wq",    32'(write_qualified), 32'(m_mode == MW && m_age >= WR_SETTLE));
      chk("m_rq",    32'(read_qualified),  32'(m_mode == MR));
      chk("m_oe",    32'(db_oe),           32'(m_mode == MR && m_age >= 1));
      chk("m_db",    32'(db_out),          32'(m_db));
      chk("m_conf",  32'(conflict_flag),   32'(m_conf));
      chk("m_proto", 32'(proto_err_flag),  32'(m_proto));
      chk("m_cnt",   32'(conflict_count),  32'(m_cnt));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge xclk);
    #1;
  endtask

  task automatic bus_idle();
    cs = 1'b1; re = 1'b1; we = 1'b1;
  endtask

  initial begin
    reset = 1'b1; cs = 1'b0; re = 1'b0; we = 1'b1;
    ab = 8'h10; db_in = 16'h0000; src_avail = '0;
    for (int i = 0; i < NSRC; i++) src_data[16*i +: 16] = 16'h1000 + 16'(i);
    src_data[16*2 +: 16] = 16'hA5A5;

    // 1: reset during an active read request
    tick(3);
    chk("rst_oe",  32'(db_oe), 32'h0);
    chk("rst_rq",  32'(read_qualified), 32'h0);
    chk("rst_cnt", 32'(conflict_count), 32'h0);
    reset = 1'b0; bus_idle();
    tick(2);

    // 2: settled write, then a one-cycle write pulse
    ab = 8'h10; db_in = 16'h1234; cs = 1'b0; we = 1'b0;
    tick(1); chk("wr_e0", 32'(write_qualified), 32'h0);
    tick(1); chk("wr_e1", 32'(write_qualified), 32'h0);
    tick(1); chk("wr_e2", 32'(write_qualified), 32'h1);
    tick(2);
    bus_idle();
    tick(1); chk("wr_fall", 32'(write_qualified), 32'h0);
    tick(2);
    cs = 1'b0; we = 1'b0;
    tick(1);
    bus_idle();
    for (int k = 0; k < 3; k++) begin
      tick(1); chk("wr_pulse", 32'(write_qualified), 32'h0);
    end

    // 3: single-source read, turnaround, request during turnaround
    ab = 8'h20; src_avail = 8'b0000_0100; cs = 1'b0; re = 1'b0;
    tick(1); chk("rd_rq1", 32'(read_qualified), 32'h1);
             chk("rd_oe1", 32'(db_oe), 32'h0);
    tick(1); chk("rd_oe2", 32'(db_oe), 32'h1);
             chk("rd_db2", 32'(db_out), 32'h0000A5A5);
    tick(1);
    bus_idle();
    tick(1); chk("rd_turn_oe", 32'(db_oe), 32'h0);
             chk("rd_turn_rq", 32'(read_qualified), 32'h0);
    cs = 1'b0; re = 1'b0;
    tick(1); chk("rd_ign_rq", 32'(read_qualified), 32'h0);
    tick(1); chk("rd_again_rq", 32'(read_qualified), 32'h1);
    bus_idle();
    tick(2);

    // 4: conflicting reads, then saturation of the count
    src_avail = 8'b0001_0010; cs = 1'b0; re = 1'b0;
    tick(2); chk("cf_db", 32'(db_out), 32'h00001001);
             chk("cf_flag", 32'(conflict_flag), 32'h1);
             chk("cf_cnt1", 32'(conflict_count), 32'h1);
    tick(1); chk("cf_once", 32'(conflict_count), 32'h1);
    bus_idle(); tick(2);
    for (int r = 2; r <= 300; r++) begin
      cs = 1'b0; re = 1'b0; tick(2);
      bus_idle(); tick(2);
      if (r == 200) chk("cf_cnt200", 32'(conflict_count), 32'h000000C8);
    end
    chk("cf_sat", 32'(conflict_count), 32'h000000FF);

    // 5: default word, status read, status clear
    src_avail = '0; cs = 1'b0; re = 1'b0;
    tick(2); chk("def_db", 32'(db_out), 32'h00003333);
    bus_idle(); tick(2);
    ab = 8'hFF; src_avail = 8'b0001_0010; cs = 1'b0; re = 1'b0;
    tick(2); chk("stat_db", 32'(db_out), 32'h000080FF);
    bus_idle(); tick(2);
    db_in = 16'h0001; cs = 1'b0; we = 1'b0;
    tick(4); chk("clr_flag", 32'(conflict_flag), 32'h0);
             chk("clr_cnt", 32'(conflict_count), 32'h0);
    bus_idle(); tick(2);

    // 6: protocol error, status shows it, a non-clearing write leaves it
    ab = 8'h20; cs = 1'b0; re = 1'b0; we = 1'b0;
    tick(2); chk("pe_flag", 32'(proto_err_flag), 32'h1);
             chk("pe_wq", 32'(write_qualified), 32'h0);
             chk("pe_oe", 32'(db_oe), 32'h0);
    bus_idle(); tick(1);
    ab = 8'hFF; src_avail = '0; cs = 1'b0; re = 1'b0;
    tick(2); chk("pe_stat", 32'(db_out), 32'h00004000);
    bus_idle(); tick(2);
    db_in = 16'h0002; cs = 1'b0; we = 1'b0;
    tick(4); chk("noclr_pe", 32'(proto_err_flag), 32'h1);
    bus_idle(); tick(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
